samcoupe_ce_gen: RTL and testbench

Parametrised clock-enable generator for the SAM Coupé core, driving the CPU, bus/ASIC, video 4× and SAA1099 enables from a single clk_sys. It extends the fixed 6 MHz / ZX-speed scheme to four selectable CPU divisors and per-mode memory/IO contention stalling. Mode switches are glitch-free: every started CPU period completes, followed by a settle gap. Sits at the top level between the throttle/speed status bits and the T80 CEN_p/CEN_n inputs.

---
 rtl/samcoupe_ce_gen_pkg.sv | 33 +++
 rtl/samcoupe_ce_gen_if.sv | 26 ++
 rtl/samcoupe_ce_gen_ce_divider.sv | 26 ++
 rtl/samcoupe_ce_gen.sv | 137 +++++++++++++
 tb/tb_samcoupe_ce_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/samcoupe_ce_gen_pkg.sv
// Shared types, default divisors and the divisor lookup for the SAM Coupe clock-enable generator.
package samcoupe_clk_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } ce_state_t;

    typedef logic [1:0] cpu_mode_t;

    localparam int DIV0_DEF        = 16;
    localparam int DIV1_DEF        = 27;
    localparam int DIV2_DEF        = 8;
    localparam int DIV3_DEF        = 4;
    localparam int PSG_DIV_DEF     = 12;
    localparam int SETTLE_DEF      = 3;
    localparam logic [3:0] WAIT_MASK_DEF = 4'b0001;

    // CPU period for a given speed mode, with the divisor set passed in by the caller.
    function automatic int div_sel(input cpu_mode_t mode, input int d0, input int d1,
                                   input int d2, input int d3);
        int d;
        d = d3;
        case (mode)
            2'd0:    d = d0;
            2'd1:    d = d1;
            2'd2:    d = d2;
            default: d = d3;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/samcoupe_ce_gen_if.sv
// Speed-select inputs and clock-enable outputs shared between the generator and its consumers.
interface samcoupe_ce_gen_if;
    import samcoupe_clk_pkg::*;

    cpu_mode_t mode;
    logic      wait_req;
    logic      ce_cpu_p;
    logic      ce_cpu_n;
    logic      ce_bus_p;
    logic      ce_bus_n;
    logic      ce_4x;
    logic      ce_psg;
    cpu_mode_t mode_cur;
    logic      switching;

    modport master (
        input  mode, wait_req,
        output ce_cpu_p, ce_cpu_n, ce_bus_p, ce_bus_n, ce_4x, ce_psg, mode_cur, switching
    );

    modport slave (
        output mode, wait_req,
        input  ce_cpu_p, ce_cpu_n, ce_bus_p, ce_bus_n, ce_4x, ce_psg, mode_cur, switching
    );

endinterface

// File: rtl/samcoupe_ce_gen_ce_divider.sv
// Free-running modulus-N counter; pulse is high while the count is zero.
module ce_divider #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_sys,
    input  logic         reset,
    output logic [W-1:0] cnt,
    output logic         pulse
);

    // Reset parks the count at N-1 so the first cycle after release reads zero.
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= W'(N - 1);
        end else if (cnt == W'(N - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign pulse = (cnt == '0);

endmodule

// File: rtl/samcoupe_ce_gen.sv
// Clock-enable generator: fixed bus/video/PSG enables plus a CPU enable pair with
// selectable divisor, contention stalls and a settle gap on every speed change.
module samcoupe_ce_gen #(
    parameter int         DIV0      = samcoupe_clk_pkg::DIV0_DEF,
    parameter int         DIV1      = samcoupe_clk_pkg::DIV1_DEF,
    parameter int         DIV2      = samcoupe_clk_pkg::DIV2_DEF,
    parameter int         DIV3      = samcoupe_clk_pkg::DIV3_DEF,
    parameter int         PSG_DIV   = samcoupe_clk_pkg::PSG_DIV_DEF,
    parameter int         SETTLE    = samcoupe_clk_pkg::SETTLE_DEF,
    parameter logic [3:0] WAIT_MASK = samcoupe_clk_pkg::WAIT_MASK_DEF
) (
    input logic              clk_sys,
    input logic              reset,
    samcoupe_ce_gen_if.master ce_if
);
    import samcoupe_clk_pkg::ce_state_t;
    import samcoupe_clk_pkg::cpu_mode_t;
    import samcoupe_clk_pkg::div_sel;

    localparam int DMAX01  = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int DMAX23  = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int DIV_MAX = (DMAX01 > DMAX23) ? DMAX01 : DMAX23;
    localparam int CW      = $clog2(DIV_MAX);
    localparam int BW      = $clog2(DIV0);
    localparam int PW      = (PSG_DIV > 1) ? $clog2(PSG_DIV) : 1;

    if (DIV0 % 4 != 0) begin : g_bad_div0
        $error("DIV0 must be a multiple of 4");
    end
    if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin : g_bad_div
        $error("every CPU divisor must be at least 2");
    end
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("SETTLE must be in 1..15");
    end

    logic [BW-1:0] bc;
    logic          bus_zero;
    logic [PW-1:0] psg_cnt_unused;
    logic          psg_zero;

    ce_divider #(.N(DIV0)) u_bus (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cnt     (bc),
        .pulse   (bus_zero)
    );

    ce_divider #(.N(PSG_DIV)) u_psg (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cnt     (psg_cnt_unused),
        .pulse   (psg_zero)
    );

    ce_state_t     state_q, state_d;
    logic [CW-1:0] cc_q, cc_d;
    logic [3:0]    sc_q, sc_d;
    cpu_mode_t     mode_cur_q, mode_cur_d;
    logic          en_q, en_d;
    logic [CW-1:0] cc_max, cc_half;
    logic          cc_zero, cc_last, stall, cpu_p;

    assign cc_max  = CW'(div_sel(mode_cur_q, DIV0, DIV1, DIV2, DIV3) - 1);
    assign cc_half = CW'(div_sel(mode_cur_q, DIV0, DIV1, DIV2, DIV3) / 2);
    assign cc_zero = (cc_q == '0);
    assign cc_last = (cc_q == cc_max);
    assign stall   = ce_if.wait_req & WAIT_MASK[mode_cur_q];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= samcoupe_clk_pkg::RUN;
            cc_q       <= CW'(div_sel(ce_if.mode, DIV0, DIV1, DIV2, DIV3) - 1);
            sc_q       <= '0;
            mode_cur_q <= ce_if.mode;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cc_q       <= cc_d;
            sc_q       <= sc_d;
            mode_cur_q <= mode_cur_d;
            en_q       <= en_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cc_d       = cc_q;
        sc_d       = sc_q;
        mode_cur_d = mode_cur_q;
        en_d       = en_q;
        cpu_p      = 1'b0;
        case (state_q)
            samcoupe_clk_pkg::RUN: begin
                cpu_p = cc_zero & ~stall;
                if (cc_zero) en_d = ~stall;
                if (cc_last) begin
                    cc_d = '0;
                    // Speed changes only take effect once the current period has completed.
                    if (ce_if.mode != mode_cur_q) begin
                        state_d    = samcoupe_clk_pkg::SETTLE;
                        mode_cur_d = ce_if.mode;
                        sc_d       = '0;
                        en_d       = 1'b0;
                    end
                end else begin
                    cc_d = cc_q + CW'(1);
                end
            end
            samcoupe_clk_pkg::SETTLE: begin
                if (ce_if.mode != mode_cur_q) begin
                    mode_cur_d = ce_if.mode;
                    cc_d       = '0;
                    sc_d       = '0;
                end else if (cc_last) begin
                    cc_d = '0;
                    if (sc_q == 4'(SETTLE - 1)) state_d = samcoupe_clk_pkg::RUN;
                    else                        sc_d    = sc_q + 4'd1;
                end else begin
                    cc_d = cc_q + CW'(1);
                end
            end
            default: state_d = samcoupe_clk_pkg::RUN;
        endcase
    end

    assign ce_if.ce_cpu_p  = cpu_p & ~reset;
    assign ce_if.ce_cpu_n  = (cc_q == cc_half) & en_q & ~reset;
    assign ce_if.ce_bus_p  = bus_zero & ~reset;
    assign ce_if.ce_bus_n  = (bc == BW'(DIV0 / 2)) & ~reset;
    assign ce_if.ce_4x     = ((bc % BW'(DIV0 / 4)) == '0) & ~reset;
    assign ce_if.ce_psg    = psg_zero & ~reset;
    assign ce_if.mode_cur  = mode_cur_q;
    assign ce_if.switching = (state_q == samcoupe_clk_pkg::SETTLE);

endmodule

// File: tb/tb_samcoupe_ce_gen.sv
// Directed bench for samcoupe_ce_gen with default parameters; expectations are cycle-indexed from reset release.
module tb_samcoupe_ce_gen;
    import samcoupe_clk_pkg::*;

    logic clk_sys = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    samcoupe_ce_gen_if ce_if();

    samcoupe_ce_gen dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_if   (ce_if)
    );

    always #5 clk_sys = ~clk_sys;

    // {cpu_p, cpu_n, bus_p, bus_n, 4x, psg, switching, mode_cur}
    logic [8:0] obs;
    assign obs = {ce_if.ce_cpu_p, ce_if.ce_cpu_n, ce_if.ce_bus_p, ce_if.ce_bus_n,
                  ce_if.ce_4x, ce_if.ce_psg, ce_if.switching, ce_if.mode_cur};

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    // Leaves the bench one step into cycle 0 after release.
    task automatic apply_reset(input logic [1:0] m);
        reset          = 1'b1;
        ce_if.mode     = m;
        ce_if.wait_req = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    // Bus/video/PSG enables for cycle i after reset release (DIV0=16, PSG_DIV=12).
    function automatic logic [3:0] free_run(input int i);
        return {i % 16 == 0, i % 16 == 8, i % 4 == 0, i % 12 == 0};
    endfunction

    task automatic test_reset();
        logic [8:0] exp;
        reset          = 1'b1;
        ce_if.mode     = 2'd2;
        ce_if.wait_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            exp = {6'b0, 1'b0, 2'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs[8:3] !== 6'b0) begin
            errors++;
            $display("FAIL reset_release_edge: got %b expected 000000", obs[8:3]);
        end
        next_cycle();
        #1;
        exp = {1'b1, 1'b0, 4'b1011, 1'b0, 2'd2};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_first_cycle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp;
        apply_reset(2'd0);
        for (int i = 0; i < 48; i++) begin
            #1;
            exp = {i % 16 == 0, i % 16 == 8, free_run(i), 1'b0, 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic cycle %0d: got %b expected %b", i, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_wait();
        logic [8:0] exp;
        logic       skip;
        apply_reset(2'd0);
        for (int i = 0; i < 96; i++) begin
            ce_if.wait_req = (i >= 30 && i <= 50);
            #1;
            skip = (i / 16 == 2) || (i / 16 == 3);
            exp  = {i % 16 == 0 && !skip, i % 16 == 8 && !skip, free_run(i), 1'b0, 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wait_mode0 cycle %0d: got %b expected %b", i, obs, exp);
            end
            next_cycle();
        end
        apply_reset(2'd1);
        for (int i = 0; i < 108; i++) begin
            ce_if.wait_req = (i >= 20 && i <= 60);
            #1;
            exp = {i % 27 == 0, i % 27 == 13, free_run(i), 1'b0, 2'd1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wait_mode1 cycle %0d: got %b expected %b", i, obs, exp);
            end
            next_cycle();
        end
        ce_if.wait_req = 1'b0;
    endtask

    task automatic test_switch();
        logic [8:0] exp;
        apply_reset(2'd0);
        for (int i = 0; i < 131; i++) begin
            if (i == 5) ce_if.mode = 2'd1;
            #1;
            exp = {(i == 0) || (i >= 97 && (i - 97) % 27 == 0),
                   (i == 8) || (i >= 97 && (i - 97) % 27 == 13),
                   free_run(i),
                   i >= 16 && i <= 96,
                   (i < 16) ? 2'd0 : 2'd1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL switch_0_to_1 cycle %0d: got %b expected %b", i, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_restart();
        logic [8:0] exp;
        apply_reset(2'd0);
        for (int i = 0; i < 61; i++) begin
            if (i == 2)  ce_if.mode = 2'd1;
            if (i == 36) ce_if.mode = 2'd3;
            #1;
            exp = {(i == 0) || (i >= 49 && (i - 49) % 4 == 0),
                   (i == 8) || (i >= 49 && (i - 49) % 4 == 2),
                   free_run(i),
                   i >= 16 && i <= 48,
                   (i < 16) ? 2'd0 : ((i < 37) ? 2'd1 : 2'd3)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL settle_restart cycle %0d: got %b expected %b", i, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_revert();
        logic [8:0] exp;
        apply_reset(2'd0);
        for (int i = 0; i < 41; i++) begin
            if (i == 3) ce_if.mode = 2'd2;
            if (i == 9) ce_if.mode = 2'd0;
            #1;
            exp = {i % 16 == 0, i % 16 == 8, free_run(i), 1'b0, 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mode_revert cycle %0d: got %b expected %b", i, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_settle();
        logic [8:0] exp;
        apply_reset(2'd0);
        for (int i = 0; i < 30; i++) begin
            if (i == 2) ce_if.mode = 2'd1;
            #1;
            exp = {i == 0, i == 8, free_run(i), i >= 16, (i < 16) ? 2'd0 : 2'd1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pre_reset_settle cycle %0d: got %b expected %b", i, obs, exp);
            end
            next_cycle();
        end
        reset      = 1'b1;
        ce_if.mode = 2'd2;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (obs[8:3] !== 6'b0) begin
                errors++;
                $display("FAIL reset_in_settle cycle %0d: got %b expected 000000", j, obs[8:3]);
            end
            next_cycle();
        end
        reset = 1'b0;
        next_cycle();
        for (int k = 0; k < 16; k++) begin
            #1;
            exp = {k % 8 == 0, k % 8 == 4, free_run(k), 1'b0, 2'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL after_settle_reset cycle %0d: got %b expected %b", k, obs, exp);
            end
            next_cycle();
        end
    endtask

    initial begin
        reset          = 1'b1;
        ce_if.mode     = 2'd0;
        ce_if.wait_req = 1'b0;
        test_reset();
        test_basic();
        test_wait();
        test_switch();
        test_restart();
        test_revert();
        test_reset_in_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
